riscv_pert_cfg_master: RTL and testbench
========================================

Name: riscv_pert_cfg_master

Overview:
- Debug-bus initiator that programs and reads back the perturbation register file over the core debug interface (req/gnt/rvalid, 15-bit address).
- Bench-side sequencers push register commands into a small FIFO. The block serialises them into one debug transaction at a time and returns a response per command.
- It sits between the testbench stimulus code and the perturbation unit's debug input, replacing hand-written debug-bus tasks.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).
- PERT_REGS, 15, number of implemented perturbation registers; indices >= PERT_REGS are rejected.
- TIMEOUT, 64, maximum cycles spent in REQ plus WAIT for one transaction before abort.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  FIFO not full; a push occurs when cmd_valid_i & cmd_ready_o.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_idx_i  in  4  perturbation register index.
- cmd_wdata_i  in  32  write data.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_we_o  out  1  we of the completed command.
- rsp_idx_o  out  4  index of the completed command.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = bad index or timeout.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.
- dbg_req_o  out  1  debug request.
- dbg_we_o  out  1  debug write enable.
- dbg_addr_o  out  15  debug address.
- dbg_wdata_o  out  32  debug write data.
- dbg_gnt_i  in  1  grant; may be combinational from dbg_req_o.
- dbg_rvalid_i  in  1  response valid.
- dbg_rdata_i  in  32  read data, valid while dbg_rvalid_i is high.

Behaviour:
- Reset: all dbg_* outputs 0; rsp_* outputs 0; busy_o 0; FIFO empty; FSM IDLE; timeout counter 0. cmd_ready_o is 1 after reset because the FIFO is empty.
- Address encoding: dbg_addr_o = {1'b0, 6'b000110, 2'b00, idx[3:0], 2'b00}, i.e. 15'h0600 + 4*idx.
- FIFO:
  - No bypass; cmd_ready_o = !full.
  - Push and pop in the same cycle are allowed, and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - The FIFO pops only in IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE with FIFO non-empty, on the next edge:
  - If the head idx >= PERT_REGS: pop, stay IDLE, and pulse rsp_valid_o=1 with rsp_err_o=1 and rsp_rdata_o=0. No bus activity.
  - Otherwise: pop, load dbg_req_o=1, dbg_we_o, dbg_addr_o and dbg_wdata_o (wdata forced to 0 for reads), clear the timeout counter, and enter REQ.
- REQ:
  - dbg_req_o, dbg_we_o, dbg_addr_o and dbg_wdata_o are held stable.
  - On an edge with dbg_gnt_i=1: dbg_req_o<=0, dbg_wdata_o<=0, enter WAIT. dbg_addr_o and dbg_we_o are held.
  - dbg_rvalid_i is ignored in REQ.
- WAIT: on an edge with dbg_rvalid_i=1:
  - Capture dbg_rdata_i (reads only).
  - Clear dbg_addr_o and dbg_we_o.
  - Pulse rsp_valid_o with rsp_err_o=0.
  - Return to IDLE.
- Timeout:
  - The counter increments every cycle in REQ and WAIT.
  - When it reaches TIMEOUT-1 without completion, on the next edge all dbg_* outputs go to 0, rsp_valid_o pulses with rsp_err_o=1 and rsp_rdata_o=0, and the FSM returns to IDLE.
  - If gnt or rvalid arrives on that same edge, completion wins over timeout.
- Responses: rsp_* outputs are registered. rsp_valid_o is high for exactly one cycle per command. rsp_we_o, rsp_idx_o, rsp_rdata_o and rsp_err_o are held until the next response.
- Latency with a combinational-grant responder whose rvalid is registered from grant:
  - push at edge 0;
  - dbg_req_o high after edge 1;
  - dbg_req_o low after edge 2;
  - rsp_valid_o high in the cycle after edge 3.
- Back-to-back commands: the next dbg_req_o rises no earlier than the edge after rsp_valid_o rises for the previous command. At most one outstanding transaction.
- Stray dbg_rvalid_i in IDLE is ignored.
- Reset asserted mid-transaction: immediate return to reset values. FIFO contents are discarded and no response is issued.
- busy_o is combinational from FIFO count and FSM state.

Test Plan:
- Write: push we=1, idx=0, wdata=32'h0000_0003 → dbg_addr_o=15'h0600 with req, dbg_wdata_o=3 until grant; rsp_valid_o 3 cycles after push with rsp_err_o=0, rsp_rdata_o=0; the responder's reg 0 now reads 3.
- Readback: push write idx=9 data 32'd100, then read idx=9 → read transaction uses addr 15'h0624; rsp_rdata_o=32'd100 on the second response; the second dbg_req_o starts only after the first rsp_valid_o.
- Bad index: push read idx=15 → no dbg_req_o edge; rsp_valid_o the cycle after the pop with rsp_err_o=1, rsp_idx_o=15.
- Timeout: responder holds dbg_gnt_i=0, TIMEOUT=8 → dbg_req_o high exactly 8 cycles, then all dbg_* outputs 0 and rsp_err_o=1; the next queued command then proceeds normally.
- Backpressure: hold grant low and push 6 commands with FIFO_DEPTH=4 → cmd_ready_o low once 4 entries are queued; all accepted commands complete in order, checked by rsp_idx_o sequence; the final busy_o is 0.
- Reset mid-op: assert rst_ni=0 while in WAIT → dbg_* outputs, rsp_valid_o and busy_o go to 0 asynchronously; a later rvalid pulse produces no response.

Source files
------------

// File: rtl/riscv_pert_cfg_master.sv
// riscv_pert_cfg_master
// Debug-bus initiator for the perturbation register file. Commands are
// queued in a small FIFO and issued one at a time as req/gnt/rvalid debug
// transactions. Every command gets exactly one registered response pulse.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), async active-low reset
//   cmd_valid_i/ready_o   command push handshake (ready = FIFO not full)
//   cmd_we_i/idx_i/wdata_i  command fields
//   rsp_valid_o           one-cycle response pulse
//   rsp_we_o/idx_o/rdata_o/err_o  response fields, held until next response
//   busy_o                FIFO non-empty or transaction in flight
//   dbg_req_o/we_o/addr_o/wdata_o  debug bus request side
//   dbg_gnt_i/rvalid_i/rdata_i     debug bus grant and response side
module riscv_pert_cfg_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int PERT_REGS  = 15,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_idx_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_we_o,
  output logic [3:0]  rsp_idx_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        dbg_req_o,
  output logic        dbg_we_o,
  output logic [14:0] dbg_addr_o,
  output logic [31:0] dbg_wdata_o,
  input  logic        dbg_gnt_i,
  input  logic        dbg_rvalid_i,
  input  logic [31:0] dbg_rdata_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);
  localparam logic [4:0]    IDX_LIM = 5'(PERT_REGS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  logic          fifoWe_q   [FIFO_DEPTH];
  logic [3:0]    fifoIdx_q  [FIFO_DEPTH];
  logic [31:0]   fifoData_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dbgReq_q, dbgReq_d;
  logic          dbgWe_q, dbgWe_d;
  logic [14:0]   dbgAddr_q, dbgAddr_d;
  logic [31:0]   dbgWdata_q, dbgWdata_d;
  logic          rspValid_q, rspValid_d;
  logic          rspWe_q, rspWe_d;
  logic [3:0]    rspIdx_q, rspIdx_d;
  logic [31:0]   rspRdata_q, rspRdata_d;
  logic          rspErr_q, rspErr_d;

  logic        push, popEn, doAbort;
  logic        headWe;
  logic [3:0]  headIdx;
  logic [31:0] headData;

  assign cmd_ready_o = (count_q != DEPTH_C);
  assign push        = cmd_valid_i & cmd_ready_o;
  assign headWe      = fifoWe_q[rdPtr_q];
  assign headIdx     = fifoIdx_q[rdPtr_q];
  assign headData    = fifoData_q[rdPtr_q];
  assign busy_o      = (count_q != '0) || (state_q != IDLE);

  // FIFO storage needs no reset; only the pointers and count define content.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoWe_q[wrPtr_q]   <= cmd_we_i;
      fifoIdx_q[wrPtr_q]  <= cmd_idx_i;
      fifoData_q[wrPtr_q] <= cmd_wdata_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push)  wrPtr_q <= wrPtr_q + PW'(1);
      if (popEn) rdPtr_q <= rdPtr_q + PW'(1);
      case ({push, popEn})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transaction sequencing. The response index comes from the held address
  // bits, so no separate copy of the in-flight index is kept.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dbgReq_d   = dbgReq_q;
    dbgWe_d    = dbgWe_q;
    dbgAddr_d  = dbgAddr_q;
    dbgWdata_d = dbgWdata_q;
    rspValid_d = 1'b0;
    rspWe_d    = rspWe_q;
    rspIdx_d   = rspIdx_q;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    popEn      = 1'b0;
    doAbort    = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          popEn = 1'b1;
          if ({1'b0, headIdx} >= IDX_LIM) begin
            rspValid_d = 1'b1;
            rspErr_d   = 1'b1;
            rspRdata_d = '0;
            rspWe_d    = headWe;
            rspIdx_d   = headIdx;
          end else begin
            dbgReq_d   = 1'b1;
            dbgWe_d    = headWe;
            dbgAddr_d  = {1'b0, 6'b000110, 2'b00, headIdx, 2'b00};
            dbgWdata_d = headWe ? headData : 32'h0;
            timer_d    = '0;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (dbg_gnt_i) begin
          dbgReq_d   = 1'b0;
          dbgWdata_d = '0;
          timer_d    = timer_q + TW'(1);
          state_d    = WAIT;
        end else if (timer_q == TLAST) begin
          doAbort = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT: begin
        if (dbg_rvalid_i) begin
          rspValid_d = 1'b1;
          rspErr_d   = 1'b0;
          rspWe_d    = dbgWe_q;
          rspIdx_d   = dbgAddr_q[5:2];
          rspRdata_d = dbgWe_q ? 32'h0 : dbg_rdata_i;
          dbgAddr_d  = '0;
          dbgWe_d    = 1'b0;
          state_d    = IDLE;
        end else if (timer_q == TLAST) begin
          doAbort = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion is checked first above, so an abort only happens when
    // neither grant nor rvalid arrived on the final allowed edge.
    if (doAbort) begin
      rspValid_d = 1'b1;
      rspErr_d   = 1'b1;
      rspRdata_d = '0;
      rspWe_d    = dbgWe_q;
      rspIdx_d   = dbgAddr_q[5:2];
      dbgReq_d   = 1'b0;
      dbgWe_d    = 1'b0;
      dbgAddr_d  = '0;
      dbgWdata_d = '0;
      state_d    = IDLE;
    end
  end

  // State, bus and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      dbgReq_q   <= 1'b0;
      dbgWe_q    <= 1'b0;
      dbgAddr_q  <= '0;
      dbgWdata_q <= '0;
      rspValid_q <= 1'b0;
      rspWe_q    <= 1'b0;
      rspIdx_q   <= '0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dbgReq_q   <= dbgReq_d;
      dbgWe_q    <= dbgWe_d;
      dbgAddr_q  <= dbgAddr_d;
      dbgWdata_q <= dbgWdata_d;
      rspValid_q <= rspValid_d;
      rspWe_q    <= rspWe_d;
      rspIdx_q   <= rspIdx_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign dbg_req_o   = dbgReq_q;
  assign dbg_we_o    = dbgWe_q;
  assign dbg_addr_o  = dbgAddr_q;
  assign dbg_wdata_o = dbgWdata_q;
  assign rsp_valid_o = rspValid_q;
  assign rsp_we_o    = rspWe_q;
  assign rsp_idx_o   = rspIdx_q;
  assign rsp_rdata_o = rspRdata_q;
  assign rsp_err_o   = rspErr_q;

endmodule

// File: tb/tb_riscv_pert_cfg_master.sv
// tb_riscv_pert_cfg_master
// Directed and randomized bench for riscv_pert_cfg_master. A bench-side
// responder models the perturbation unit's register file; a monitor records
// responses and request edges, and the expected responses come from a
// command-order model of the register file.
module tb_riscv_pert_cfg_master;

  localparam int TIMEOUT_C = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [3:0]  cmd_idx_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o, rsp_we_o, rsp_err_o, busy_o;
  logic [3:0]  rsp_idx_o;
  logic [31:0] rsp_rdata_o;
  logic        dbg_req_o, dbg_we_o, dbg_gnt_i, dbg_rvalid_i;
  logic [14:0] dbg_addr_o;
  logic [31:0] dbg_wdata_o, dbg_rdata_i;

  riscv_pert_cfg_master #(.FIFO_DEPTH(4), .PERT_REGS(15), .TIMEOUT(TIMEOUT_C)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_idx_i(cmd_idx_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_idx_o(rsp_idx_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .dbg_req_o(dbg_req_o), .dbg_we_o(dbg_we_o), .dbg_addr_o(dbg_addr_o),
    .dbg_wdata_o(dbg_wdata_o), .dbg_gnt_i(dbg_gnt_i), .dbg_rvalid_i(dbg_rvalid_i),
    .dbg_rdata_i(dbg_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder: combinational grant, rvalid registered from grant.
  logic        gntEnable = 1'b1, rvalidEnable = 1'b1, forceRvalid = 1'b0;
  logic        memClear = 1'b0, randStall = 1'b0, stallGnt = 1'b1;
  logic        pendQ = 1'b0;
  logic [31:0] rdataQ = '0;
  logic [31:0] respMem [16];
  int          stallRun = 0;

  assign dbg_gnt_i    = gntEnable & stallGnt & dbg_req_o;
  assign dbg_rvalid_i = (pendQ & rvalidEnable) | forceRvalid;
  assign dbg_rdata_i  = rdataQ;

  always @(posedge clk_i) begin
    if (memClear) begin
      for (int i = 0; i < 16; i++) respMem[i] <= '0;
    end else if (dbg_req_o && dbg_gnt_i && dbg_we_o) begin
      respMem[dbg_addr_o[5:2]] <= dbg_wdata_o;
    end
    if (dbg_req_o && dbg_gnt_i) begin
      pendQ  <= 1'b1;
      rdataQ <= dbg_we_o ? 32'h0 : respMem[dbg_addr_o[5:2]];
    end else if (dbg_rvalid_i) begin
      pendQ <= 1'b0;
    end
  end

  // Random grant stalls, never more than three in a row so no timeout occurs.
  always @(negedge clk_i) begin
    if (randStall && stallRun < 3 && $urandom_range(0, 1) == 1) begin
      stallGnt = 1'b0;
      stallRun++;
    end else begin
      stallGnt = 1'b1;
      stallRun = 0;
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic        dbgQuiet;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [14:0] addr;
    logic [31:0] wdata;
  } req_t;

  rsp_t rspQ[$];
  rsp_t expQ[$];
  req_t reqQ[$];
  int   reqHigh = 0;
  logic prevReq = 1'b0;

  // Monitor: records every response pulse and every rising request edge.
  always @(negedge clk_i) begin
    rsp_t r;
    req_t q;
    if (rsp_valid_o) begin
      r.we = rsp_we_o; r.idx = rsp_idx_o; r.rdata = rsp_rdata_o;
      r.err = rsp_err_o; r.cyc = cyc;
      r.dbgQuiet = !(dbg_req_o | dbg_we_o | (|dbg_addr_o) | (|dbg_wdata_o));
      rspQ.push_back(r);
    end
    if (dbg_req_o) reqHigh++;
    if (dbg_req_o && !prevReq) begin
      q.cyc = cyc; q.we = dbg_we_o; q.addr = dbg_addr_o; q.wdata = dbg_wdata_o;
      reqQ.push_back(q);
    end
    prevReq = dbg_req_o;
  end

  int          checks = 0;
  int          failures = 0;
  int          lastPushCyc = 0;
  logic [31:0] modelMem [16];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: commands complete in push order against a flat register file.
  task automatic modelPush(input logic we, input logic [3:0] idx, input logic [31:0] data);
    rsp_t e;
    e.we = we; e.idx = idx; e.cyc = 0; e.dbgQuiet = 1'b0;
    if (int'(idx) >= 15) begin
      e.err = 1'b1; e.rdata = '0;
    end else begin
      e.err = 1'b0;
      if (we) begin
        modelMem[idx] = data;
        e.rdata = '0;
      end else begin
        e.rdata = modelMem[idx];
      end
    end
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] idx, input logic [31:0] data);
    int waitCnt = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_idx_i = idx; cmd_wdata_i = data;
    while (!cmd_ready_o && waitCnt < 100) begin
      @(negedge clk_i);
      waitCnt++;
    end
    if (!cmd_ready_o) begin
      checkOutput("push_accept", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b0;
    end else begin
      @(posedge clk_i);
      #1;
      lastPushCyc = cyc;
      cmd_valid_i = 1'b0;
      modelPush(we, idx, data);
    end
  endtask

  task automatic waitResponses(input int target, input int bound);
    int n = 0;
    while (rspQ.size() < target && n < bound) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (rspQ.size() < target) checkOutput("rsp_wait", 32'(rspQ.size()), 32'(target));
  endtask

  initial begin
    int b, rb, p, rh0, eb;
    logic we;
    logic [3:0] idx;
    logic [31:0] data;
    cmd_valid_i = 0; cmd_we_i = 0; cmd_idx_i = '0; cmd_wdata_i = '0;
    for (int i = 0; i < 16; i++) modelMem[i] = '0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    memClear = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rst_dbg_req", 32'(dbg_req_o), 0);
    checkOutput("rst_dbg_we", 32'(dbg_we_o), 0);
    checkOutput("rst_dbg_addr", 32'(dbg_addr_o), 0);
    checkOutput("rst_dbg_wdata", dbg_wdata_o, 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 0);
    checkOutput("rst_rsp_rdata", rsp_rdata_o, 0);
    checkOutput("rst_rsp_err", 32'(rsp_err_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 1);
    @(negedge clk_i);
    memClear = 1'b0;
    rst_ni = 1'b1;

    $display("[TB] write idx0");
    b = rspQ.size(); rb = reqQ.size();
    applyStimulus(1'b1, 4'd0, 32'h3);
    p = lastPushCyc;
    waitResponses(b + 1, 20);
    if (reqQ.size() > rb) begin
      checkOutput("wr_req_cyc", 32'(reqQ[rb].cyc), 32'(p + 1));
      checkOutput("wr_req_addr", 32'(reqQ[rb].addr), 32'h0600);
      checkOutput("wr_req_we", 32'(reqQ[rb].we), 1);
      checkOutput("wr_req_wdata", reqQ[rb].wdata, 32'h3);
    end else checkOutput("wr_req_seen", 32'(reqQ.size()), 32'(rb + 1));
    if (rspQ.size() > b) begin
      checkOutput("wr_rsp_cyc", 32'(rspQ[b].cyc), 32'(p + 3));
      checkOutput("wr_rsp_err", 32'(rspQ[b].err), 0);
      checkOutput("wr_rsp_rdata", rspQ[b].rdata, 0);
      checkOutput("wr_rsp_idx", 32'(rspQ[b].idx), 0);
    end
    checkOutput("wr_resp_mem0", respMem[0], 32'h3);
    b = rspQ.size();
    applyStimulus(1'b0, 4'd0, 32'h0);
    waitResponses(b + 1, 20);
    if (rspQ.size() > b) checkOutput("rd_idx0_rdata", rspQ[b].rdata, 32'h3);

    $display("[TB] readback idx9");
    b = rspQ.size(); rb = reqQ.size();
    applyStimulus(1'b1, 4'd9, 32'd100);
    applyStimulus(1'b0, 4'd9, 32'hDEAD);
    waitResponses(b + 2, 30);
    if (reqQ.size() > rb + 1 && rspQ.size() > b + 1) begin
      checkOutput("rb_req_addr", 32'(reqQ[rb + 1].addr), 32'h0624);
      checkOutput("rb_req_we", 32'(reqQ[rb + 1].we), 0);
      checkOutput("rb_req_wdata", reqQ[rb + 1].wdata, 0);
      checkOutput("rb_rsp_rdata", rspQ[b + 1].rdata, 32'd100);
      checkOutput("rb_req_after_rsp", 32'(reqQ[rb + 1].cyc > rspQ[b].cyc), 1);
    end else checkOutput("rb_seen", 32'(reqQ.size()), 32'(rb + 2));

    $display("[TB] bad index");
    b = rspQ.size(); rb = reqQ.size();
    applyStimulus(1'b0, 4'd15, 32'h0);
    p = lastPushCyc;
    waitResponses(b + 1, 10);
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("bad_no_req", 32'(reqQ.size()), 32'(rb));
    if (rspQ.size() > b) begin
      checkOutput("bad_rsp_cyc", 32'(rspQ[b].cyc), 32'(p + 1));
      checkOutput("bad_rsp_err", 32'(rspQ[b].err), 1);
      checkOutput("bad_rsp_idx", 32'(rspQ[b].idx), 15);
      checkOutput("bad_rsp_rdata", rspQ[b].rdata, 0);
    end

    $display("[TB] timeout");
    gntEnable = 1'b0;
    b = rspQ.size(); rh0 = reqHigh;
    applyStimulus(1'b0, 4'd3, 32'h0);
    p = lastPushCyc;
    applyStimulus(1'b1, 4'd4, 32'hABC);
    waitResponses(b + 1, 40);
    gntEnable = 1'b1;
    checkOutput("to_req_high", 32'(reqHigh - rh0), 32'(TIMEOUT_C));
    if (rspQ.size() > b) begin
      checkOutput("to_rsp_cyc", 32'(rspQ[b].cyc), 32'(p + TIMEOUT_C + 1));
      checkOutput("to_rsp_err", 32'(rspQ[b].err), 1);
      checkOutput("to_rsp_rdata", rspQ[b].rdata, 0);
      checkOutput("to_rsp_idx", 32'(rspQ[b].idx), 3);
      checkOutput("to_dbg_quiet", 32'(rspQ[b].dbgQuiet), 1);
    end
    waitResponses(b + 2, 20);
    if (rspQ.size() > b + 1) begin
      checkOutput("to_next_err", 32'(rspQ[b + 1].err), 0);
      checkOutput("to_next_idx", 32'(rspQ[b + 1].idx), 4);
    end
    checkOutput("to_next_mem4", respMem[4], 32'hABC);

    $display("[TB] backpressure");
    gntEnable = 1'b0;
    b = rspQ.size();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 4'(i), 32'(i * 16));
    checkOutput("bp_ready_low", 32'(cmd_ready_o), 0);
    checkOutput("bp_busy", 32'(busy_o), 1);
    gntEnable = 1'b1;
    applyStimulus(1'b1, 4'd6, 32'd96);
    waitResponses(b + 6, 200);
    for (int i = 0; i < 6; i++)
      if (rspQ.size() > b + i) checkOutput("bp_rsp_idx", 32'(rspQ[b + i].idx), 32'(i + 1));
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("bp_final_busy", 32'(busy_o), 0);

    $display("[TB] reset mid-transaction");
    rvalidEnable = 1'b0;
    applyStimulus(1'b0, 4'd2, 32'h0);
    applyStimulus(1'b1, 4'd5, 32'h7);
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rmo_in_wait_req", 32'(dbg_req_o), 0);
    checkOutput("rmo_in_wait_addr", 32'(dbg_addr_o), 32'h0608);
    b = rspQ.size();
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("rmo_dbg_req", 32'(dbg_req_o), 0);
    checkOutput("rmo_dbg_we", 32'(dbg_we_o), 0);
    checkOutput("rmo_dbg_addr", 32'(dbg_addr_o), 0);
    checkOutput("rmo_dbg_wdata", dbg_wdata_o, 0);
    checkOutput("rmo_rsp_valid", 32'(rsp_valid_o), 0);
    checkOutput("rmo_busy", 32'(busy_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rvalidEnable = 1'b1;
    @(negedge clk_i);
    forceRvalid = 1'b1;
    @(negedge clk_i);
    forceRvalid = 1'b0;
    repeat (4) @(negedge clk_i);
    #1;
    checkOutput("rmo_no_rsp", 32'(rspQ.size()), 32'(b));
    checkOutput("rmo_busy_after", 32'(busy_o), 0);

    $display("[TB] randomized commands");
    @(negedge clk_i);
    memClear = 1'b1;
    @(negedge clk_i);
    memClear = 1'b0;
    for (int i = 0; i < 16; i++) modelMem[i] = '0;
    randStall = 1'b1;
    eb = expQ.size(); b = rspQ.size();
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      data = $urandom;
      applyStimulus(we, idx, data);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    waitResponses(b + 40, 2000);
    randStall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rspQ.size() > b + i) begin
        checkOutput("rnd_we", 32'(rspQ[b + i].we), 32'(expQ[eb + i].we));
        checkOutput("rnd_idx", 32'(rspQ[b + i].idx), 32'(expQ[eb + i].idx));
        checkOutput("rnd_err", 32'(rspQ[b + i].err), 32'(expQ[eb + i].err));
        checkOutput("rnd_rdata", rspQ[b + i].rdata, expQ[eb + i].rdata);
      end
    end
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("final_busy", 32'(busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
